data_ring_writer: RTL and testbench
===================================

DATA_RING_WRITER -- requirements
Module: data_ring_writer

Interface
REQ-001 SHALL have parameter DATA_ADDRESS_WIDTH, default 12, RAM word address width.
REQ-002 SHALL have parameter DATA_OFFSET_WIDTH, default 10, head offset width relative to data_uptr.
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 16, input sample width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock.
REQ-005 SHALL have rst input 1, asynchronous active-high reset.
REQ-006 SHALL have init input 1, load ring bounds and clear head.
REQ-007 SHALL have data_uptr input DATA_ADDRESS_WIDTH, lowest ring address.
REQ-008 SHALL have data_lptr input DATA_ADDRESS_WIDTH, highest ring address.
REQ-009 SHALL have in_valid input 1, sample offered.
REQ-010 SHALL have in_data input SAMPLE_WIDTH, sample value.
REQ-011 SHALL have in_ready output 1, writer accepts sample this cycle.
REQ-012 SHALL have ram_we output 1, RAM write strobe.
REQ-013 SHALL have ram_addr output DATA_ADDRESS_WIDTH, RAM write address.
REQ-014 SHALL have ram_wdata output SAMPLE_WIDTH, RAM write data.
REQ-015 SHALL have head_offset output DATA_OFFSET_WIDTH, offset of newest written sample from data_uptr.
REQ-016 SHALL have new_smpl output 1, newest sample committed, convolution may start.
REQ-017 SHALL have smpl_ack input 1, conversion controller consumed new_smpl.

Function
REQ-018 SHALL implement FSM states UNCFG, READY, WRITE, NOTIFY.
REQ-019 UNCFG: in_ready=0; init=1 -> latch uptr/lptr, wptr offset=0, head_offset=0, go READY.
REQ-020 READY: in_ready=1; in_valid=1 -> latch in_data, go WRITE next cycle.
REQ-021 WRITE: exactly one cycle, ram_we=1, ram_addr=uptr_reg+wptr, ram_wdata=latched sample; go NOTIFY.
REQ-022 On leaving WRITE: head_offset<=wptr; wptr<=0 if uptr_reg+wptr==lptr_reg, else wptr+1 (wrap-around).
REQ-023 NOTIFY: new_smpl=1 held until smpl_ack=1; same cycle as ack go READY; in_ready=0 in NOTIFY.
REQ-024 smpl_ack outside NOTIFY SHALL be ignored.
REQ-025 init=1 in any state SHALL override: relatch bounds, wptr=0, head_offset=0, new_smpl=0, go READY; sample in flight is dropped without RAM write.
REQ-026 Address sum SHALL be modulo 2**DATA_ADDRESS_WIDTH; offset zero-extended.
REQ-027 Accept-to-RAM-write latency SHALL be 1 cycle; max throughput one sample per 3 cycles when ack is immediate.
REQ-028 uptr==lptr SHALL yield a single-entry ring: every write to uptr, head_offset always 0.
REQ-029 ram_we SHALL be 0 in all states except WRITE; ram_addr/ram_wdata don't-care when ram_we=0.

Reset
REQ-030 rst SHALL asynchronously force UNCFG, in_ready=0, ram_we=0, new_smpl=0, head_offset=0, wptr=0, bound registers 0.
REQ-031 rst asserted mid-WRITE SHALL suppress the write in the same cycle.

Configuration
REQ-032 With RBUF_PRIMED_EN defined: output primed (1 bit) SHALL be 0 after reset/init and set after the write that first wraps wptr to 0; sticky until rst/init.
REQ-033 Without RBUF_PRIMED_EN: no primed port; other behaviour identical.

Structure
REQ-034 FSM state encoding and command localparams SHALL live in shared package src_ctrl_pkg alongside the existing controller encodings.
REQ-035 Wrap logic SHALL be sub-module ring_wptr (load, inc, bounds in; wptr, wrap out); no other sub-modules.

Verification
REQ-036 uptr=0x010, lptr=0x013, 5 samples 0xA1..0xA5 with immediate ack -> writes to 0x010,0x011,0x012,0x013,0x010; head_offset 0,1,2,3,0.
REQ-037 in_valid=1 before init -> in_ready=0, no ram_we; after init first accept writes at uptr.
REQ-038 smpl_ack delayed 10 cycles -> new_smpl held 10 cycles, in_ready=0 throughout, no second write.
REQ-039 init pulsed in WRITE cycle with new bounds 0x100/0x1FF -> write suppressed, next sample written at 0x100.
REQ-040 rst asserted asynchronously mid-NOTIFY -> new_smpl and head_offset 0 before next clk edge.
REQ-041 RBUF_PRIMED_EN, ring 0x000..0x003 -> primed=0 after 3 writes, 1 after 4th, stays 1 after 5th.

Source files
------------

// File: rtl/src_ctrl_pkg.sv
// Shared source-controller encodings: ring-writer FSM states and
// write-pointer command codes used by data_ring_writer.
package src_ctrl_pkg;

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        READY  = 2'd1,
        WRITE  = 2'd2,
        NOTIFY = 2'd3
    } ring_wr_state_t;

    localparam logic [1:0] WPTR_CMD_HOLD = 2'd0;
    localparam logic [1:0] WPTR_CMD_LOAD = 2'd1;
    localparam logic [1:0] WPTR_CMD_INC  = 2'd2;

endpackage

// File: rtl/data_ring_writer_if.sv
// Sample-stream, RAM-write and new-sample notification signals of the ring writer.
// master = writer side, slave = producer / RAM / conversion-controller side.
interface data_ring_writer_if #(
    parameter int DATA_ADDRESS_WIDTH = 12,
    parameter int SAMPLE_WIDTH       = 16
);
    logic                          in_valid;
    logic [SAMPLE_WIDTH-1:0]       in_data;
    logic                          in_ready;
    logic                          ram_we;
    logic [DATA_ADDRESS_WIDTH-1:0] ram_addr;
    logic [SAMPLE_WIDTH-1:0]       ram_wdata;
    logic                          new_smpl;
    logic                          smpl_ack;

    modport master (
        input  in_valid, in_data, smpl_ack,
        output in_ready, ram_we, ram_addr, ram_wdata, new_smpl
    );

    modport slave (
        output in_valid, in_data, smpl_ack,
        input  in_ready, ram_we, ram_addr, ram_wdata, new_smpl
    );
endinterface

// File: rtl/ring_wptr.sv
// Ring write pointer: offset from the lower ring bound that wraps back to zero
// after the slot addressed by the upper bound has been written.
module ring_wptr #(
    parameter int DATA_ADDRESS_WIDTH = 12,
    parameter int DATA_OFFSET_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          inc,
    input  logic [DATA_ADDRESS_WIDTH-1:0] uptr,
    input  logic [DATA_ADDRESS_WIDTH-1:0] lptr,
    output logic [DATA_OFFSET_WIDTH-1:0]  wptr,
    output logic                          wrap
);
    logic [DATA_OFFSET_WIDTH-1:0]  wptr_r;
    logic [DATA_ADDRESS_WIDTH-1:0] addr_s;

    assign addr_s = uptr + DATA_ADDRESS_WIDTH'(wptr_r);
    assign wrap   = (addr_s == lptr);
    assign wptr   = wptr_r;

    // Pointer register; load has priority over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= '0;
        end else if (load) begin
            wptr_r <= '0;
        end else if (inc) begin
            if (wrap) begin
                wptr_r <= '0;
            end else begin
                wptr_r <= wptr_r + DATA_OFFSET_WIDTH'(1'b1);
            end
        end else begin
            wptr_r <= wptr_r;
        end
    end
endmodule

// File: rtl/data_ring_writer.sv
// Writes accepted samples into a RAM ring [data_uptr..data_lptr] and notifies the
// conversion controller. Optional `primed` output enabled by RBUF_PRIMED_EN.
module data_ring_writer
    import src_ctrl_pkg::*;
#(
    parameter int DATA_ADDRESS_WIDTH = 12,
    parameter int DATA_OFFSET_WIDTH  = 10,
    parameter int SAMPLE_WIDTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init,
    input  logic [DATA_ADDRESS_WIDTH-1:0] data_uptr,
    input  logic [DATA_ADDRESS_WIDTH-1:0] data_lptr,
    data_ring_writer_if.master            bus,
    output logic [DATA_OFFSET_WIDTH-1:0]  head_offset
`ifdef RBUF_PRIMED_EN
    ,
    output logic                          primed
`endif
);
    ring_wr_state_t                state_r;
    logic [DATA_ADDRESS_WIDTH-1:0] uptr_r;
    logic [DATA_ADDRESS_WIDTH-1:0] lptr_r;
    logic                          in_ready_r;
    logic                          ram_we_r;
    logic [DATA_ADDRESS_WIDTH-1:0] ram_addr_r;
    logic [SAMPLE_WIDTH-1:0]       ram_wdata_r;
    logic                          new_smpl_r;
    logic [DATA_OFFSET_WIDTH-1:0]  head_offset_r;

    logic [1:0]                    wptr_cmd_s;
    logic                          wptr_load_s;
    logic                          wptr_inc_s;
    logic [DATA_OFFSET_WIDTH-1:0]  wptr_s;
    logic                          wrap_s;
    logic [DATA_ADDRESS_WIDTH-1:0] wr_addr_s;

    assign wr_addr_s = uptr_r + DATA_ADDRESS_WIDTH'(wptr_s);

    // Pointer command: init reloads, leaving WRITE advances, otherwise hold.
    always_comb begin
        wptr_cmd_s = WPTR_CMD_HOLD;
        if (init) begin
            wptr_cmd_s = WPTR_CMD_LOAD;
        end else if (state_r == WRITE) begin
            wptr_cmd_s = WPTR_CMD_INC;
        end else begin
            wptr_cmd_s = WPTR_CMD_HOLD;
        end
    end

    assign wptr_load_s = (wptr_cmd_s == WPTR_CMD_LOAD);
    assign wptr_inc_s  = (wptr_cmd_s == WPTR_CMD_INC);

    ring_wptr #(
        .DATA_ADDRESS_WIDTH (DATA_ADDRESS_WIDTH),
        .DATA_OFFSET_WIDTH  (DATA_OFFSET_WIDTH)
    ) u_ring_wptr (
        .clk  (clk),
        .rst  (rst),
        .load (wptr_load_s),
        .inc  (wptr_inc_s),
        .uptr (uptr_r),
        .lptr (lptr_r),
        .wptr (wptr_s),
        .wrap (wrap_s)
    );

    // Writer FSM with registered outputs; init overrides every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= UNCFG;
            uptr_r        <= '0;
            lptr_r        <= '0;
            in_ready_r    <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= '0;
            ram_wdata_r   <= '0;
            new_smpl_r    <= 1'b0;
            head_offset_r <= '0;
        end else if (init) begin
            state_r       <= READY;
            uptr_r        <= data_uptr;
            lptr_r        <= data_lptr;
            in_ready_r    <= 1'b1;
            ram_we_r      <= 1'b0;
            new_smpl_r    <= 1'b0;
            head_offset_r <= '0;
        end else begin
            case (state_r)
                UNCFG: begin
                    in_ready_r <= 1'b0;
                    ram_we_r   <= 1'b0;
                    new_smpl_r <= 1'b0;
                end
                READY: begin
                    if (bus.in_valid) begin
                        state_r     <= WRITE;
                        in_ready_r  <= 1'b0;
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= wr_addr_s;
                        ram_wdata_r <= bus.in_data;
                    end else begin
                        in_ready_r  <= 1'b1;
                        ram_we_r    <= 1'b0;
                    end
                end
                WRITE: begin
                    state_r       <= NOTIFY;
                    ram_we_r      <= 1'b0;
                    new_smpl_r    <= 1'b1;
                    head_offset_r <= wptr_s;
                end
                NOTIFY: begin
                    if (bus.smpl_ack) begin
                        state_r    <= READY;
                        new_smpl_r <= 1'b0;
                        in_ready_r <= 1'b1;
                    end else begin
                        new_smpl_r <= 1'b1;
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= UNCFG;
                    in_ready_r <= 1'b0;
                    ram_we_r   <= 1'b0;
                    new_smpl_r <= 1'b0;
                end
            endcase
        end
    end

    // init in the same cycle cancels a pending write or accept.
    assign bus.in_ready  = in_ready_r & ~init;
    assign bus.ram_we    = ram_we_r & ~init;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_wdata = ram_wdata_r;
    assign bus.new_smpl  = new_smpl_r;
    assign head_offset   = head_offset_r;

`ifdef RBUF_PRIMED_EN
    logic primed_r;

    // Sticky flag: set by the first write that wraps the pointer back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_r <= 1'b0;
        end else if (init) begin
            primed_r <= 1'b0;
        end else if (wptr_inc_s && wrap_s) begin
            primed_r <= 1'b1;
        end else begin
            primed_r <= primed_r;
        end
    end

    assign primed = primed_r;
`else
    logic unused_wrap_s;
    assign unused_wrap_s = wrap_s;
`endif
endmodule

// File: tb/tb_data_ring_writer.sv
// Directed bench for data_ring_writer: table of cycle vectors plus hand-written
// sequences for delayed ack, init during WRITE, async reset and single-entry rings.
module tb_data_ring_writer;
    localparam int AW = 12;
    localparam int OW = 10;
    localparam int SW = 16;

    typedef struct {
        logic          init;
        logic          valid;
        logic [SW-1:0] data;
        logic          ack;
        logic          e_ready;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_wdata;
        logic          e_new;
        logic [OW-1:0] e_head;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic [AW-1:0] data_uptr;
    logic [AW-1:0] data_lptr;
    logic [OW-1:0] head_offset;
`ifdef RBUF_PRIMED_EN
    logic          primed;
`endif

    int n_pass  = 0;
    int n_total = 0;
    vec_t vq[$];

    data_ring_writer_if #(.DATA_ADDRESS_WIDTH(AW), .SAMPLE_WIDTH(SW)) bus ();

    data_ring_writer #(
        .DATA_ADDRESS_WIDTH (AW),
        .DATA_OFFSET_WIDTH  (OW),
        .SAMPLE_WIDTH       (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .data_uptr   (data_uptr),
        .data_lptr   (data_lptr),
        .bus         (bus),
        .head_offset (head_offset)
`ifdef RBUF_PRIMED_EN
        ,
        .primed      (primed)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic i_init, input logic valid, input logic [SW-1:0] data,
                         input logic ack);
        init          = i_init;
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.smpl_ack  = ack;
    endtask

    task automatic outs(input string tag, input logic er, input logic ew, input logic [AW-1:0] ea,
                        input logic [SW-1:0] ed, input logic en, input logic [OW-1:0] eh);
        check({tag, ".in_ready"}, bus.in_ready, er);
        check({tag, ".ram_we"}, bus.ram_we, ew);
        if (ew) begin
            check({tag, ".ram_addr"}, bus.ram_addr, ea);
            check({tag, ".ram_wdata"}, bus.ram_wdata, ed);
        end
        check({tag, ".new_smpl"}, bus.new_smpl, en);
        check({tag, ".head_offset"}, head_offset, eh);
    endtask

    // Inputs already driven at edge+1; check at edge+2, then advance one cycle.
    task automatic step(input string tag, input logic er, input logic ew, input logic [AW-1:0] ea,
                        input logic [SW-1:0] ed, input logic en, input logic [OW-1:0] eh);
        #1;
        outs(tag, er, ew, ea, ed, en, eh);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic i_init, input logic valid, input logic [SW-1:0] data,
                       input logic ack, input logic er, input logic ew, input logic [AW-1:0] ea,
                       input logic [SW-1:0] ed, input logic en, input logic [OW-1:0] eh);
        vec_t v;
        v = '{i_init, valid, data, ack, er, ew, ea, ed, en, eh};
        vq.push_back(v);
    endtask

    // Accept, write and immediately acknowledge one sample.
    task automatic write_one(input string tag, input logic [SW-1:0] data, input logic [AW-1:0] ea,
                             input logic [OW-1:0] head_before, input logic [OW-1:0] head_after);
        drive(1'b0, 1'b1, data, 1'b0);
        step({tag, ".acc"}, 1'b1, 1'b0, '0, '0, 1'b0, head_before);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        step({tag, ".wr"}, 1'b0, 1'b1, ea, data, 1'b0, head_before);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        step({tag, ".ntf"}, 1'b0, 1'b0, '0, '0, 1'b1, head_after);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        data_uptr = 12'h000;
        data_lptr = 12'h000;
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #12;
        outs("reset", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Valid before init is ignored, then init and five samples round a 4-slot ring.
        add(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 10'd0);
        add(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 10'd0);
        add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 10'd0);
        for (int k = 0; k < 5; k++) begin
            logic [OW-1:0] hb;
            logic [OW-1:0] ha;
            logic [AW-1:0] ad;
            logic [SW-1:0] dv;
            hb = (k == 0) ? 10'd0 : OW'(k - 1);
            ha = OW'(k % 4);
            ad = 12'h010 + AW'(k % 4);
            dv = 16'h00A1 + SW'(k);
            add(1'b0, 1'b1, dv, 1'b0, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, hb);
            add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, ad, dv, 1'b0, hb);
            add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, ha);
        end

        data_uptr = 12'h010;
        data_lptr = 12'h013;
        foreach (vq[i]) begin
            drive(vq[i].init, vq[i].valid, vq[i].data, vq[i].ack);
            step($sformatf("vec%0d", i), vq[i].e_ready, vq[i].e_we, vq[i].e_addr,
                 vq[i].e_wdata, vq[i].e_new, vq[i].e_head);
        end

        // Delayed ack: new_smpl held 10 cycles, in_valid held high but not accepted.
        drive(1'b0, 1'b1, 16'h00B1, 1'b0);
        step("dly.acc", 1'b1, 1'b0, '0, '0, 1'b0, 10'd0);
        drive(1'b0, 1'b1, 16'h00B2, 1'b1);
        step("dly.wr", 1'b0, 1'b1, 12'h011, 16'h00B1, 1'b0, 10'd0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 16'h00B2, (k == 9) ? 1'b1 : 1'b0);
            step($sformatf("dly.hold%0d", k), 1'b0, 1'b0, '0, '0, 1'b1, 10'd1);
        end
        drive(1'b0, 1'b1, 16'h00B2, 1'b0);
        step("dly.acc2", 1'b1, 1'b0, '0, '0, 1'b0, 10'd1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        step("dly.wr2", 1'b0, 1'b1, 12'h012, 16'h00B2, 1'b0, 10'd1);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        step("dly.ntf2", 1'b0, 1'b0, '0, '0, 1'b1, 10'd2);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        step("ack_idle", 1'b1, 1'b0, '0, '0, 1'b0, 10'd2);

        // init during WRITE drops the sample and reloads the ring bounds.
        drive(1'b0, 1'b1, 16'h00C1, 1'b0);
        step("ini.acc", 1'b1, 1'b0, '0, '0, 1'b0, 10'd2);
        data_uptr = 12'h100;
        data_lptr = 12'h1FF;
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        step("ini.wr", 1'b0, 1'b0, '0, '0, 1'b0, 10'd2);
        write_one("ini.next", 16'h00C2, 12'h100, 10'd0, 10'd0);

        // Async reset mid-NOTIFY clears outputs before the next edge.
        drive(1'b0, 1'b1, 16'h00D1, 1'b0);
        step("rstn.acc", 1'b1, 1'b0, '0, '0, 1'b0, 10'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        step("rstn.wr", 1'b0, 1'b1, 12'h101, 16'h00D1, 1'b0, 10'd0);
        #1;
        outs("rstn.pre", 1'b0, 1'b0, '0, '0, 1'b1, 10'd1);
        rst = 1'b1;
        #1;
        outs("rstn.async", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'h00D2, 1'b0);
        step("rstn.uncfg", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);

        // Async reset mid-WRITE suppresses the strobe; then a single-entry ring.
        data_uptr = 12'h020;
        data_lptr = 12'h020;
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        step("rstw.init", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);
        drive(1'b0, 1'b1, 16'h00E1, 1'b0);
        step("rstw.acc", 1'b1, 1'b0, '0, '0, 1'b0, 10'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        outs("rstw.pre", 1'b0, 1'b1, 12'h020, 16'h00E1, 1'b0, 10'd0);
        rst = 1'b1;
        #1;
        outs("rstw.async", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        step("one.init", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);
        write_one("one.w1", 16'h00E2, 12'h020, 10'd0, 10'd0);
        write_one("one.w2", 16'h00E3, 12'h020, 10'd0, 10'd0);
        write_one("one.w3", 16'h00E4, 12'h020, 10'd0, 10'd0);

`ifdef RBUF_PRIMED_EN
        // primed rises with the write that first wraps the pointer, and stays set.
        data_uptr = 12'h000;
        data_lptr = 12'h003;
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        step("prm.init", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);
        check("prm.after_init", primed, 1'b0);
        for (int k = 0; k < 5; k++) begin
            write_one($sformatf("prm.w%0d", k), 16'h00F0 + SW'(k), AW'(k % 4),
                      (k == 0) ? 10'd0 : OW'((k - 1) % 4), OW'(k % 4));
            check($sformatf("prm.primed%0d", k), primed, (k >= 3) ? 1'b1 : 1'b0);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        step("prm.reinit", 1'b0, 1'b0, '0, '0, 1'b0, 10'd0);
        check("prm.cleared", primed, 1'b0);
`endif

        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
